uart_cmd_bridge: RTL and testbench

//   Byte-level command parser between a UART byte receiver/transmitter and an

---
 rtl/uart_cmd_bridge.sv | 124 ++++++++++++
 tb/tb_uart_cmd_bridge.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_bridge.sv
// UART byte-stream command parser driving a 128 x 32-bit register bus.
// Write frames are 5 bytes, read frames are 1 byte answered by 4 tx bytes.
module uart_cmd_bridge #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rxData,
  input  logic        rxValid,
  output logic [7:0]  txData,
  output logic        txSend,
  input  logic        txBusy,
  output logic        we,
  output logic [6:0]  addr,
  output logic [31:0] wdat,
  input  logic [31:0] rdat
);

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_STROBE,
    RD_LATCH,
    TX_LOAD,
    TX_GUARD,
    TX_WAIT
  } state_e;

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic [31:0] sh_q;
  logic [31:0] tmo_q;
  logic        we_q;
  logic        txs_q;
  logic [7:0]  txd_q;
  logic [6:0]  addr_q;
  logic [31:0] wdat_q;

  assign txData = txd_q;
  assign txSend = txs_q;
  assign we     = we_q;
  assign addr   = addr_q;
  assign wdat   = wdat_q;

  // Frame FSM; every output is a register so the bus and tx see clean edges.
  // Write bytes collect in sh_q and only reach wdat on frame completion,
  // so an aborted frame leaves the last committed wdat untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      sh_q    <= 32'd0;
      tmo_q   <= 32'd0;
      we_q    <= 1'b0;
      txs_q   <= 1'b0;
      txd_q   <= 8'd0;
      addr_q  <= 7'd0;
      wdat_q  <= 32'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q <= 2'd0;
          tmo_q <= 32'd0;
          if (rxValid) begin
            addr_q  <= rxData[6:0];
            state_q <= rxData[7] ? RD_LATCH : WR_DATA;
          end
        end
        WR_DATA: begin
          if (rxValid) begin
            tmo_q <= 32'd0;
            sh_q  <= {sh_q[23:0], rxData};
            if (cnt_q == 2'd3) begin
              wdat_q  <= {sh_q[23:0], rxData};
              we_q    <= 1'b1;
              state_q <= WR_STROBE;
            end else begin
              cnt_q <= cnt_q + 2'd1;
            end
          end else if (TIMEOUT != 0 && tmo_q == TIMEOUT - 1) begin
            tmo_q   <= 32'd0;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        WR_STROBE: begin
          we_q    <= 1'b0;
          state_q <= IDLE;
        end
        RD_LATCH: begin
          sh_q    <= rdat;
          cnt_q   <= 2'd0;
          state_q <= TX_LOAD;
        end
        TX_LOAD: begin
          if (!txBusy) begin
            txd_q   <= sh_q[31:24];
            sh_q    <= {sh_q[23:0], 8'd0};
            txs_q   <= 1'b1;
            state_q <= TX_GUARD;
          end
        end
        TX_GUARD: begin
          // Give the transmitter one clock to raise txBusy.
          txs_q   <= 1'b0;
          state_q <= TX_WAIT;
        end
        TX_WAIT: begin
          if (!txBusy) begin
            if (cnt_q == 2'd3) begin
              state_q <= IDLE;
            end else begin
              cnt_q   <= cnt_q + 2'd1;
              state_q <= TX_LOAD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed bench for uart_cmd_bridge with a small register file
// and a busy-for-N-clocks transmitter model.
module tb_uart_cmd_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rxData = 8'd0;
  logic        rxValid = 1'b0;
  logic [7:0]  txData;
  logic        txSend;
  logic        txBusy;
  logic        we;
  logic [6:0]  addr;
  logic [31:0] wdat;
  logic [31:0] rdat;

  int tests = 0;
  int fails = 0;

  logic [31:0] regs [128];
  int          we_cnt = 0;
  logic [6:0]  we_addr = 7'd0;
  logic [31:0] we_data = 32'd0;
  logic [7:0]  txq [$];
  int          busy_cnt = 0;
  logic        hold = 1'b0;
  int          base;

  uart_cmd_bridge #(.TIMEOUT(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .rxData  (rxData),
    .rxValid (rxValid),
    .txData  (txData),
    .txSend  (txSend),
    .txBusy  (txBusy),
    .we      (we),
    .addr    (addr),
    .wdat    (wdat),
    .rdat    (rdat)
  );

  always #5 clk = ~clk;

  // Register file: address 0F mirrors reg 7F plus FF.
  assign rdat = (addr == 7'h0F) ? regs[7'h7F] + 32'hFF : regs[addr];

  always @(posedge clk) begin
    if (we) begin
      regs[addr] <= wdat;
      we_cnt     <= we_cnt + 1;
      we_addr    <= addr;
      we_data    <= wdat;
    end
  end

  // Transmitter: busy for 5 clocks after each txSend.
  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= 0;
    else if (txSend) busy_cnt <= 5;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign txBusy = hold || (busy_cnt != 0);

  always @(posedge clk) begin
    if (txSend) txq.push_back(txData);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rxData  = b;
    rxValid = 1'b1;
    @(negedge clk);
    rxValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_frame(input logic [7:0] a, input logic [31:0] d);
    send_byte(a);
    send_byte(d[31:24]);
    send_byte(d[23:16]);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
    idle(3);
  endtask

  // Bounded wait for n captured tx bytes, then settle back to IDLE.
  task automatic wait_tx(input string tag, input int n);
    for (int i = 0; i < 400; i++) begin
      if (txq.size() >= n) break;
      @(negedge clk);
    end
    idle(12);
    chk(tag, txq.size(), n);
  endtask

  task automatic chk_read(input string tag, input logic [31:0] v);
    if (txq.size() == 4) begin
      chk({tag, "_b0"}, {24'd0, txq[0]}, {24'd0, v[31:24]});
      chk({tag, "_b1"}, {24'd0, txq[1]}, {24'd0, v[23:16]});
      chk({tag, "_b2"}, {24'd0, txq[2]}, {24'd0, v[15:8]});
      chk({tag, "_b3"}, {24'd0, txq[3]}, {24'd0, v[7:0]});
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) regs[i] = 32'h1000 + i;

    // Reset values while rst is held.
    idle(2);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_txsend", {31'd0, txSend}, 32'd0);
    chk("rst_addr", {25'd0, addr}, 32'd0);
    chk("rst_wdat", wdat, 32'd0);
    chk("rst_txdata", {24'd0, txData}, 32'd0);
    rst = 1'b0;
    idle(2);

    // Two rounds of write 7F then read 0F.
    for (int r = 0; r < 2; r++) begin
      base = we_cnt;
      wr_frame(8'h7F, 32'h9955AA00);
      chk("wr_cnt", we_cnt - base, 1);
      chk("wr_addr", {25'd0, we_addr}, 32'h7F);
      chk("wr_data", we_data, 32'h9955AA00);
      chk("wr_wdat_hold", wdat, 32'h9955AA00);
      chk("wr_we_low", {31'd0, we}, 32'd0);
      txq.delete();
      send_byte(8'h8F);
      wait_tx("rd_count", 4);
      chk_read("rd", 32'h9955AAFF);
      chk("rd_txdata_hold", {24'd0, txData}, 32'hFF);
      chk("rd_no_we", we_cnt - base, 1);
    end

    // Transmitter held busy; a stray byte during the response is dropped.
    txq.delete();
    hold = 1'b1;
    send_byte(8'h8F);
    idle(5);
    send_byte(8'h01);
    idle(13);
    chk("hold_no_send", txq.size(), 0);
    hold = 1'b0;
    wait_tx("hold_count", 4);
    chk_read("hold", 32'h9955AAFF);
    chk("hold_drop_addr", {25'd0, addr}, 32'h0F);

    // Gap shorter than the timeout keeps the frame alive.
    base = we_cnt;
    send_byte(8'h3C);
    send_byte(8'h12);
    idle(12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    idle(3);
    chk("gap_cnt", we_cnt - base, 1);
    chk("gap_wdat", wdat, 32'h12345678);
    chk("gap_addr", {25'd0, addr}, 32'h3C);

    // Gap beyond the timeout aborts, then a full frame works.
    base = we_cnt;
    send_byte(8'h7F);
    send_byte(8'h11);
    idle(30);
    chk("tmo_no_we", we_cnt - base, 0);
    chk("tmo_wdat", wdat, 32'h12345678);
    wr_frame(8'h05, 32'h01020304);
    chk("tmo_next_cnt", we_cnt - base, 1);
    chk("tmo_next_addr", {25'd0, we_addr}, 32'h05);
    chk("tmo_next_data", we_data, 32'h01020304);

    // Reset after two data bytes.
    base = we_cnt;
    send_byte(8'h22);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_we", {31'd0, we}, 32'd0);
    chk("mrst_addr", {25'd0, addr}, 32'd0);
    chk("mrst_wdat", wdat, 32'd0);
    chk("mrst_txdata", {24'd0, txData}, 32'd0);
    chk("mrst_txsend", {31'd0, txSend}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    chk("mrst_no_we", we_cnt - base, 0);
    wr_frame(8'h22, 32'hDEADBEEF);
    chk("mrst_next_cnt", we_cnt - base, 1);
    chk("mrst_next_addr", {25'd0, we_addr}, 32'h22);
    chk("mrst_next_data", we_data, 32'hDEADBEEF);
    txq.delete();
    send_byte(8'hA2);
    wait_tx("mrst_rd_count", 4);
    chk_read("mrst_rd", 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
